// File: rtl/if_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
// Optional feature macro: IF_MISALIGN_TRAP_EN (misaligned redirect trap).
package if_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_HOLD,
    S_TRAP
  } fetch_st_t;

  localparam logic [31:0] NOP_INSTR_D = 32'h0000_0033;
  localparam logic [31:0] RESET_PC_D  = 32'h0000_0000;
  localparam logic [31:0] PC_STEP     = 32'd4;

endpackage

// File: rtl/if_fetch_stage_hold_buf.sv
// One-entry capture register for an instruction word and its PC,
// used while the pipeline stalls on a returned fetch.
module if_hold_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic        i_clr,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc
);

  logic [31:0] r_instr;
  logic [31:0] r_pc;

  // capture on load, zero on clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_instr <= '0;
      r_pc    <= '0;
    end else if (i_load) begin
      r_instr <= i_instr;
      r_pc    <= i_pc;
    end else if (i_clr) begin
      r_instr <= '0;
      r_pc    <= '0;
    end
  end

  assign o_instr = r_instr;
  assign o_pc    = r_pc;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: PC, single-outstanding imem fetch, stall hold.
// Optional macro IF_MISALIGN_TRAP_EN enables the misaligned redirect trap.
module if_fetch_stage
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_D,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_D
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_instrn,
  output logic [31:0] if_pc_addrout,
  output logic [31:0] if_pcp4,
  output logic        if_bubble,
  output logic        misalign_o
);

  fetch_st_t   r_state;
  fetch_st_t   w_state_nx;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nx;
  logic        r_kill;
  logic        w_kill_nx;
  logic [31:0] w_tgt;
  logic        w_mis;
  logic        w_pres;
  logic [31:0] w_pc_inc;
  logic        w_load;
  logic        w_clr;
  logic [31:0] w_hold_instr;
  logic [31:0] w_hold_pc;

`ifdef IF_MISALIGN_TRAP_EN
  assign w_tgt = redirect_pc_i;
  assign w_mis = redirect_i && (redirect_pc_i[1:0] != 2'b00);
`else
  logic w_unused_lsb;
  assign w_unused_lsb = ^redirect_pc_i[1:0];
  assign w_tgt = {redirect_pc_i[31:2], 2'b00};
  assign w_mis = 1'b0;
`endif

  assign w_pres = (r_state == S_HOLD) ||
                  (r_state == S_WAIT && imem_rvalid && !r_kill);
  assign w_pc_inc = r_pc + PC_STEP;

  if_hold_buf u_hold (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_clr   (w_clr),
    .i_instr (imem_rdata),
    .i_pc    (r_pc),
    .o_instr (w_hold_instr),
    .o_pc    (w_hold_pc)
  );

  // state, pc and kill registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_kill  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_pc    <= w_pc_nx;
      r_kill  <= w_kill_nx;
    end
  end

  // next state plus the fetch request issued on each transition
  always_comb begin
    w_state_nx = r_state;
    w_pc_nx    = r_pc;
    w_kill_nx  = r_kill;
    imem_req   = 1'b0;
    imem_addr  = {r_pc[31:2], 2'b00};
    w_load     = 1'b0;
    w_clr      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_mis) begin
          w_pc_nx    = w_tgt;
          w_state_nx = S_TRAP;
        end else if (redirect_i) begin
          w_pc_nx    = w_tgt;
          imem_req   = 1'b1;
          imem_addr  = w_tgt;
          w_state_nx = S_WAIT;
        end else begin
          imem_req   = 1'b1;
          w_state_nx = S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_mis) begin
          w_pc_nx    = w_tgt;
          w_kill_nx  = !imem_rvalid;
          w_state_nx = S_TRAP;
        end else if (redirect_i) begin
          w_pc_nx = w_tgt;
          if (imem_rvalid) begin
            w_kill_nx = 1'b0;
            imem_req  = 1'b1;
            imem_addr = w_tgt;
          end else begin
            w_kill_nx = 1'b1;
          end
        end else if (imem_rvalid) begin
          if (r_kill) begin
            w_kill_nx = 1'b0;
            imem_req  = 1'b1;
          end else if (stall_i) begin
            w_load     = 1'b1;
            w_state_nx = S_HOLD;
          end else begin
            w_pc_nx   = w_pc_inc;
            imem_req  = 1'b1;
            imem_addr = w_pc_inc;
          end
        end
      end
      S_HOLD: begin
        if (w_mis) begin
          w_pc_nx    = w_tgt;
          w_clr      = 1'b1;
          w_state_nx = S_TRAP;
        end else if (redirect_i) begin
          w_pc_nx    = w_tgt;
          imem_req   = 1'b1;
          imem_addr  = w_tgt;
          w_clr      = 1'b1;
          w_state_nx = S_WAIT;
        end else if (!stall_i) begin
          w_pc_nx    = w_pc_inc;
          imem_req   = 1'b1;
          imem_addr  = w_pc_inc;
          w_clr      = 1'b1;
          w_state_nx = S_WAIT;
        end
      end
      S_TRAP: begin
        if (imem_rvalid) w_kill_nx = 1'b0;
        if (w_mis) begin
          w_pc_nx = w_tgt;
        end else if (redirect_i) begin
          w_pc_nx    = w_tgt;
          w_state_nx = S_WAIT;
          if (!(r_kill && !imem_rvalid)) begin
            imem_req  = 1'b1;
            imem_addr = w_tgt;
          end
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // presentation towards IF/ID; redirect always forces a bubble
  always_comb begin
    if_bubble     = !w_pres || redirect_i;
    if_pc_addrout = (r_state == S_HOLD) ? w_hold_pc : r_pc;
    if_pcp4       = if_pc_addrout + PC_STEP;
    misalign_o    = w_mis;
    if (if_bubble)
      if_instrn = NOP_INSTR;
    else if (r_state == S_HOLD)
      if_instrn = w_hold_instr;
    else
      if_instrn = imem_rdata;
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage with a latency-configurable imem model.
// Build with or without IF_MISALIGN_TRAP_EN.
module tb_if_fetch_stage;

  logic        clk;
  logic        rst;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] if_instrn;
  logic [31:0] if_pc_addrout;
  logic [31:0] if_pcp4;
  logic        if_bubble;
  logic        misalign_o;

  int n_chk = 0;
  int n_err = 0;

  logic        pend;
  logic [31:0] paddr;
  int          pcnt;
  int          lat;

  localparam logic [31:0] NOP = 32'h0000_0033;

  if_fetch_stage dut (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .if_instrn     (if_instrn),
    .if_pc_addrout (if_pc_addrout),
    .if_pcp4       (if_pcp4),
    .if_bubble     (if_bubble),
    .misalign_o    (misalign_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mw(input logic [31:0] a);
    if (a == 32'h8) return 32'h00A0_0093;
    return a ^ 32'h1300_0013;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  // advance one cycle and update the imem model
  task automatic nxt();
    logic        rq;
    logic [31:0] ad;
    logic        had;
    rq  = imem_req;
    ad  = imem_addr;
    had = imem_rvalid;
    @(posedge clk);
    #1;
    if (rst) begin
      pend        = 1'b0;
      imem_rvalid = 1'b0;
    end else begin
      if (had) pend = 1'b0;
      if (rq) begin
        chk("one_outstanding", {31'd0, pend}, 32'd0);
        pend  = 1'b1;
        paddr = ad;
        pcnt  = lat;
      end
      if (pend && pcnt > 0) pcnt--;
      imem_rvalid = pend && (pcnt == 0);
      imem_rdata  = imem_rvalid ? mw(paddr) : 32'hDEAD_BEEF;
    end
  endtask

  task automatic present(input string tag, input logic [31:0] pc);
    chk({tag, "_bub"}, {31'd0, if_bubble}, 32'd0);
    chk({tag, "_ins"}, if_instrn, mw(pc));
    chk({tag, "_pc"}, if_pc_addrout, pc);
    chk({tag, "_pcp4"}, if_pcp4, pc + 32'd4);
  endtask

  task automatic req(input string tag, input logic r,
                     input logic [31:0] a);
    chk({tag, "_req"}, {31'd0, imem_req}, {31'd0, r});
    if (r) chk({tag, "_addr"}, imem_addr, a);
  endtask

  initial begin
    rst = 1'b1;
    stall_i = 1'b0;
    redirect_i = 1'b0;
    redirect_pc_i = '0;
    imem_rvalid = 1'b0;
    imem_rdata = '0;
    pend = 1'b0;
    paddr = '0;
    pcnt = 0;
    lat = 1;

    // reset state
    settle();
    chk("rst_bub", {31'd0, if_bubble}, 32'd1);
    chk("rst_ins", if_instrn, NOP);
    chk("rst_pc", if_pc_addrout, 32'h0);
    chk("rst_pcp4", if_pcp4, 32'h4);
    chk("rst_mis", {31'd0, misalign_o}, 32'd0);
    nxt();
    rst = 1'b0;

    // sequential fetch, latency 1
    settle();
    chk("c0_bub", {31'd0, if_bubble}, 32'd1);
    req("c0", 1'b1, 32'h0);
    nxt();
    settle();
    present("c1", 32'h0);
    req("c1", 1'b1, 32'h4);
    nxt();
    settle();
    present("c2", 32'h4);
    req("c2", 1'b1, 32'h8);
    nxt();

    // stall 3 cycles on word at 0x8
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      present("stall", 32'h8);
      chk("stall_word", if_instrn, 32'h00A0_0093);
      req("stall", 1'b0, 32'h0);
      nxt();
    end
    stall_i = 1'b0;
    lat = 3;
    settle();
    present("unstall", 32'h8);
    req("unstall", 1'b1, 32'hC);
    nxt();

    // redirect during outstanding fetch, latency 3
    settle();
    chk("w1_bub", {31'd0, if_bubble}, 32'd1);
    req("w1", 1'b0, 32'h0);
    nxt();
    redirect_i = 1'b1;
    redirect_pc_i = 32'h100;
    settle();
    chk("rd_bub", {31'd0, if_bubble}, 32'd1);
    req("rd", 1'b0, 32'h0);
    nxt();
    redirect_i = 1'b0;
    settle();
    chk("drop_bub", {31'd0, if_bubble}, 32'd1);
    chk("drop_ins", if_instrn, NOP);
    req("drop", 1'b1, 32'h100);
    nxt();
    settle();
    chk("w2_bub", {31'd0, if_bubble}, 32'd1);
    nxt();
    lat = 1;
    settle();
    chk("w3_bub", {31'd0, if_bubble}, 32'd1);
    nxt();
    settle();
    present("rdp", 32'h100);
    req("rdp", 1'b1, 32'h104);
    nxt();

    // redirect and stall together from HOLD
    stall_i = 1'b1;
    settle();
    present("h0", 32'h104);
    nxt();
    redirect_i = 1'b1;
    redirect_pc_i = 32'h100;
    settle();
    chk("hr_bub", {31'd0, if_bubble}, 32'd1);
    chk("hr_ins", if_instrn, NOP);
    req("hr", 1'b1, 32'h100);
    nxt();
    redirect_i = 1'b0;
    stall_i = 1'b0;
    settle();
    present("hrp", 32'h100);
    req("hrp", 1'b1, 32'h104);
    nxt();

    // pc wrap
    redirect_i = 1'b1;
    redirect_pc_i = 32'hFFFF_FFFC;
    settle();
    chk("wr_bub", {31'd0, if_bubble}, 32'd1);
    req("wr", 1'b1, 32'hFFFF_FFFC);
    nxt();
    redirect_i = 1'b0;
    settle();
    present("wrap", 32'hFFFF_FFFC);
    chk("wrap_pcp4", if_pcp4, 32'h0);
    req("wrap", 1'b1, 32'h0);
    nxt();

    // misaligned redirect
    redirect_i = 1'b1;
    redirect_pc_i = 32'h102;
    settle();
    chk("ma_bub", {31'd0, if_bubble}, 32'd1);
`ifdef IF_MISALIGN_TRAP_EN
    chk("ma_mis", {31'd0, misalign_o}, 32'd1);
    req("ma", 1'b0, 32'h0);
    nxt();
    redirect_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      settle();
      chk("trap_mis", {31'd0, misalign_o}, 32'd0);
      chk("trap_bub", {31'd0, if_bubble}, 32'd1);
      req("trap", 1'b0, 32'h0);
      nxt();
    end
    redirect_i = 1'b1;
    redirect_pc_i = 32'h200;
    settle();
    chk("tx_mis", {31'd0, misalign_o}, 32'd0);
    req("tx", 1'b1, 32'h200);
    nxt();
    redirect_i = 1'b0;
    settle();
    present("tx", 32'h200);
    nxt();
`else
    chk("ma_mis", {31'd0, misalign_o}, 32'd0);
    req("ma", 1'b1, 32'h100);
    nxt();
    redirect_i = 1'b0;
    settle();
    present("ma", 32'h100);
    nxt();
`endif

    // reset mid-fetch, stray rvalid in IDLE ignored
    lat = 3;
    rst = 1'b1;
    settle();
    chk("rr_bub", {31'd0, if_bubble}, 32'd1);
    chk("rr_pc", if_pc_addrout, 32'h0);
    nxt();
    rst = 1'b0;
    lat = 1;
    imem_rvalid = 1'b1;
    imem_rdata = 32'hFFFF_FFFF;
    settle();
    chk("idle_bub", {31'd0, if_bubble}, 32'd1);
    chk("idle_ins", if_instrn, NOP);
    req("idle", 1'b1, 32'h0);
    nxt();
    settle();
    present("rr", 32'h0);
    nxt();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
